// File: rtl/tabl_sweep_if.sv
// Bundle between the tabl_sweep stage and its surroundings: the sweep
// handshake (start/busy/done/result/match) plus the x/y connection to the
// tabl primitive. When TABL_SWEEP_ERRCNT_EN is defined the interface also
// carries the err_count/first_err diagnostics.
interface tabl_sweep_if;
    logic        start;
    logic [3:0]  x;
    logic        y;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        match;
`ifdef TABL_SWEEP_ERRCNT_EN
    logic [4:0]  err_count;
    logic [4:0]  first_err;

    modport master (
        output start, y,
        input  x, busy, done, result, match, err_count, first_err
    );

    modport slave (
        input  start, y,
        output x, busy, done, result, match, err_count, first_err
    );
`else
    modport master (
        output start, y,
        input  x, busy, done, result, match
    );

    modport slave (
        input  start, y,
        output x, busy, done, result, match
    );
`endif
endinterface

// File: rtl/tabl_sweep.sv
// Clocked, restartable sweep/checker for the 4-input tabl primitive.
// Walks x through codes 0..15, holding each for SETTLE+1 cycles, captures y
// into a 16-bit signature and compares it with EXPECTED once the sweep ends.
// Optional feature macro: TABL_SWEEP_ERRCNT_EN adds err_count/first_err.
module tabl_sweep #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'h0AC5
) (
    input logic         clk,
    input logic         rst,
    tabl_sweep_if.slave bus
);

    if (SETTLE > 15) begin : g_settle_check
        $error("tabl_sweep: SETTLE must be in the range 0..15");
    end

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] result_q, result_d;
    logic        match_q, match_d;
`ifdef TABL_SWEEP_ERRCNT_EN
    logic [4:0]  err_count_q, err_count_d;
    logic [4:0]  first_err_q, first_err_d;
    logic        sample_bad;
`endif

    // Next-state logic: launch on start, pace codes with the settle counter,
    // capture y at the end of each hold window, then emit the done pulse.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        match_d  = match_q;
`ifdef TABL_SWEEP_ERRCNT_EN
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        sample_bad  = (bus.y !== EXPECTED[x_q]);
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = HOLD;
                    x_d      = 4'd0;
                    cnt_d    = 4'd0;
                    busy_d   = 1'b1;
                    result_d = 16'h0000;
                    match_d  = 1'b0;
`ifdef TABL_SWEEP_ERRCNT_EN
                    err_count_d = 5'd0;
                    first_err_d = 5'd16;
`endif
                end
            end
            HOLD: begin
                if (cnt_q != SETTLE_CNT) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d         = 4'd0;
                    result_d[x_q] = bus.y;
`ifdef TABL_SWEEP_ERRCNT_EN
                    if (sample_bad) begin
                        err_count_d = err_count_q + 5'd1;
                        if (first_err_q == 5'd16) begin
                            first_err_d = {1'b0, x_q};
                        end
                    end
`endif
                    if (x_q != 4'd15) begin
                        x_d = x_q + 4'd1;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                x_d     = 4'd0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                match_d = (result_q === EXPECTED);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= 4'd0;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 16'h0000;
            match_q  <= 1'b0;
`ifdef TABL_SWEEP_ERRCNT_EN
            err_count_q <= 5'd0;
            first_err_q <= 5'd16;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            match_q  <= match_d;
`ifdef TABL_SWEEP_ERRCNT_EN
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
`endif
        end
    end

    assign bus.x      = x_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.match  = match_q;
`ifdef TABL_SWEEP_ERRCNT_EN
    assign bus.err_count = err_count_q;
    assign bus.first_err = first_err_q;
`endif

endmodule

// File: tb/tb_tabl_sweep.sv
// Self-checking bench for tabl_sweep. Two instances share clock and reset:
// one with SETTLE=1, one with SETTLE=0. A truth-table model of the tabl
// primitive (optionally faulted) drives y from each instance's x. Expected
// timing, x sequence, signature and diagnostics come from the sweep rules.
module tb_tabl_sweep;

    localparam logic [15:0] GOLDEN = 16'h0AC5;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] primTable;
    int          nChecks = 0;
    int          nFails  = 0;
    logic [15:0] lastRes [2];
    logic        lastMatch [2];

    tabl_sweep_if bus1 ();
    tabl_sweep_if bus0 ();

    tabl_sweep #(.SETTLE(1), .EXPECTED(GOLDEN)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    tabl_sweep #(.SETTLE(0), .EXPECTED(GOLDEN)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Behavioural tabl primitive: y is the table bit addressed by x.
    always_comb begin
        bus1.y = primTable[bus1.x];
        bus0.y = primTable[bus0.x];
    end

    function automatic int errCount(input logic [15:0] t);
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            if (t[i] !== GOLDEN[i]) n++;
        end
        return n;
    endfunction

    function automatic int firstErr(input logic [15:0] t);
        for (int i = 0; i < 16; i++) begin
            if (t[i] !== GOLDEN[i]) return i;
        end
        return 16;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic val);
        if (sel) bus1.start = val;
        else     bus0.start = val;
    endtask

    // Full result/diagnostic check of one instance against a model value.
    task automatic checkResult(input bit sel, input logic [15:0] expRes, input logic expMatch,
                               input int expErr, input int expFirst);
        checkOutput("result", sel ? bus1.result : bus0.result, 32'(expRes));
        checkOutput("match", sel ? bus1.match : bus0.match, 32'(expMatch));
`ifdef TABL_SWEEP_ERRCNT_EN
        checkOutput("err_count", sel ? bus1.err_count : bus0.err_count, expErr);
        checkOutput("first_err", sel ? bus1.first_err : bus0.first_err, expFirst);
`else
        if (expErr < 0 || expFirst < 0) checkOutput("diag_args", 32'(expErr), 32'(expFirst));
`endif
    endtask

    // Idle cycles: no done pulse and a stable result/match.
    task automatic idleCycles(input bit sel, input int n);
        repeat (n) begin
            @(negedge clk);
            checkOutput("idle_done", sel ? bus1.done : bus0.done, 0);
            checkOutput("idle_result", sel ? bus1.result : bus0.result, 32'(lastRes[sel]));
            checkOutput("idle_match", sel ? bus1.match : bus0.match, 32'(lastMatch[sel]));
        end
    endtask

    // One sweep: pulse start, optionally pulse start again at the first
    // cycle of codes busyA/busyB, check x/busy/done every cycle and the
    // signature in the done cycle.
    task automatic runSweep(input bit sel, input logic [15:0] tbl, input int busyA, input int busyB);
        int  s1;
        int  last;
        int  xExp;
        logic expMatch;
        s1   = sel ? 2 : 1;
        last = 16 * s1 + 1;
        expMatch = (tbl === GOLDEN);
        primTable = tbl;
        @(negedge clk);
        checkOutput("pre_done", sel ? bus1.done : bus0.done, 0);
        applyStimulus(sel, 1'b1);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            applyStimulus(sel, ((busyA >= 0 && k == busyA * s1) || (busyB >= 0 && k == busyB * s1)) ? 1'b1 : 1'b0);
            if (k == last)         xExp = 0;
            else if (k / s1 > 15)  xExp = 15;
            else                   xExp = k / s1;
            checkOutput("x_step", 32'(sel ? bus1.x : bus0.x), xExp);
            checkOutput("busy", sel ? bus1.busy : bus0.busy, (k < last) ? 1 : 0);
            checkOutput("done_timing", sel ? bus1.done : bus0.done, (k == last) ? 1 : 0);
            if (k == last) checkResult(sel, tbl, expMatch, errCount(tbl), firstErr(tbl));
        end
        lastRes[sel]   = tbl;
        lastMatch[sel] = expMatch;
    endtask

    // Start a sweep, assert reset while x equals abortX, then confirm the
    // sweep is abandoned without a done pulse.
    task automatic runAbort(input bit sel, input int abortX);
        int s1;
        s1 = sel ? 2 : 1;
        primTable = GOLDEN;
        @(negedge clk);
        applyStimulus(sel, 1'b1);
        for (int k = 0; k <= abortX * s1; k++) begin
            @(negedge clk);
            applyStimulus(sel, 1'b0);
        end
        checkOutput("abort_x_before", 32'(sel ? bus1.x : bus0.x), abortX);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_x", 32'(sel ? bus1.x : bus0.x), 0);
        checkOutput("abort_busy", sel ? bus1.busy : bus0.busy, 0);
        checkOutput("abort_done", sel ? bus1.done : bus0.done, 0);
        checkResult(sel, 16'h0000, 1'b0, 0, 16);
        lastRes[0] = 16'h0000; lastRes[1] = 16'h0000;
        lastMatch[0] = 1'b0;   lastMatch[1] = 1'b0;
        idleCycles(sel, 40);
    endtask

    initial begin
        logic [15:0] tbl;
        logic [15:0] mask;
        bit          sel;
        int          bA;
        int          bB;

        rst        = 1'b1;
        bus1.start = 1'b0;
        bus0.start = 1'b0;
        primTable  = GOLDEN;
        repeat (2) @(negedge clk);

        // Reset state of both instances.
        for (int s = 0; s < 2; s++) begin
            checkOutput("rst_x", 32'(s[0] ? bus1.x : bus0.x), 0);
            checkOutput("rst_busy", s[0] ? bus1.busy : bus0.busy, 0);
            checkOutput("rst_done", s[0] ? bus1.done : bus0.done, 0);
            checkResult(s[0], 16'h0000, 1'b0, 0, 16);
        end
        rst = 1'b0;
        lastRes[0] = 16'h0000; lastRes[1] = 16'h0000;
        lastMatch[0] = 1'b0;   lastMatch[1] = 1'b0;
        idleCycles(1'b1, 2);

        // Golden sweep, SETTLE=1.
        runSweep(1'b1, GOLDEN, -1, -1);
        idleCycles(1'b1, 3);

        // Primitive faulted to y=1 at x=4.
        tbl = GOLDEN | 16'h0010;
        runSweep(1'b1, tbl, -1, -1);
        idleCycles(1'b1, 2);

        // SETTLE=0 golden sweep.
        runSweep(1'b0, GOLDEN, -1, -1);
        idleCycles(1'b0, 2);

        // Reset while x=7, then a clean sweep.
        runAbort(1'b1, 7);
        runSweep(1'b1, GOLDEN, -1, -1);

        // Starts at x=3 and x=10 are ignored; then a back-to-back sweep.
        runSweep(1'b1, GOLDEN, 3, 10);
        runSweep(1'b1, GOLDEN, -1, -1);
        idleCycles(1'b1, 2);

        // Unknown y at x=9.
        tbl = GOLDEN;
        tbl[9] = 1'bx;
        runSweep(1'b1, tbl, -1, -1);
        idleCycles(1'b1, 2);

        // Randomized sweeps: random instance, fault pattern, gap, busy starts.
        for (int r = 0; r < 8; r++) begin
            sel  = 1'($urandom_range(0, 1));
            mask = ($urandom_range(0, 1) == 1) ? 16'($urandom & $urandom & $urandom) : 16'h0000;
            bA   = int'($urandom_range(0, 15));
            bB   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
            idleCycles(sel, int'($urandom_range(0, 3)));
            runSweep(sel, GOLDEN ^ mask, bA, bB);
        end
        idleCycles(1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/tabl_sweep.md
Name: tabl_sweep

Overview:
- Sequential sweep/checker stage for the 4-input truth-table primitive `tabl`.
- Drives the primitive's inputs x3..x0 through all 16 codes. After a programmable settle time, samples its output y into a 16-bit signature and compares it with the expected truth vector.
- Sits directly upstream (drives x) and downstream (consumes y) of the primitive, and replaces the free-running `initial` sweep with a clocked, restartable block.

Parameters:
- SETTLE, default 1: extra cycles x is held before y is sampled. Range 0..15. Each code occupies SETTLE+1 cycles.
- EXPECTED, default 16'h0AC5: golden truth vector. Bit i is the required y for x=i.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  sweep request; sampled only in IDLE
- x  output  4  code driven to primitive inputs x3..x0 (x[3]=x3)
- y  input  1  primitive output
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when the sweep completes
- result  output  16  captured signature; bit i = y sampled for x=i
- match  output  1  result === EXPECTED; valid from done, held until the next start

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, x=0, busy=0, done=0, result=0, match=0, settle counter=0. Reset applied mid-sweep aborts the sweep immediately: no done pulse, result cleared.
- FSM states: IDLE, HOLD, FINISH.
- IDLE, start=1: next cycle state=HOLD, x=0, busy=1, settle counter=0, result cleared to 0, match=0.
- IDLE, start=0: all outputs hold.
- HOLD, counter<SETTLE: counter increments; x holds.
- HOLD, counter==SETTLE: at this edge, result[x] <= y and counter <= 0.
  - If x!=15: x <= x+1, stay in HOLD.
  - If x==15: state <= FINISH. x stays 15 (no wrap).
- FINISH: lasts one cycle. done=1, busy=0, match=(result===EXPECTED). Next state IDLE, done returns to 0, and x returns to 0 on that transition.
- Latency: from the start edge to the done-high cycle = 16*(SETTLE+1)+1 cycles. For SETTLE=1 this is 33 cycles.
- start while busy (HOLD/FINISH): ignored, not queued.
- start high in the cycle after FINISH (state IDLE): accepted; back-to-back sweeps are allowed.
- y sampling: y is registered as-is. An X or Z sample is stored and forces match=0 (case equality).
- Width rules:
  - x is a 4-bit register, incremented only when x<15.
  - The settle counter is 4 bits.
  - SETTLE>15 is illegal; the implementation flags it with an elaboration-time $error.
- result and match are stable between done and the next accepted start.

Optional Feature:
- Macro: TABL_SWEEP_ERRCNT_EN.
- Defined: adds two output ports.
  - err_count [4:0] (0..16): number of sampled bits differing from EXPECTED (X/Z counts as a mismatch).
  - first_err [4:0]: index of the lowest mismatching code, or 5'd16 if none.
  - Both update incrementally at each sample edge. Both are cleared to 0 / 16 on reset and on start accept, and are final by the done cycle.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Golden sweep: bench models the primitive correctly, SETTLE=1, pulse start. Expect:
  - x steps 0..15, each value held 2 cycles.
  - done exactly 33 cycles after start, result=16'h0AC5, match=1.
  - With ERRCNT: err_count=0, first_err=16.
- Faulted primitive: force y=1 when x=4. Expect result=16'h0AD5, match=0. With ERRCNT: err_count=1, first_err=4.
- SETTLE=0: expect x changes every cycle, done 17 cycles after start, result=16'h0AC5.
- Mid-sweep reset: assert rst when x=7. Expect next cycle x=0, busy=0, result=0, no done pulse. A new start then yields a full correct sweep.
- Start while busy: pulse start at x=3 and at x=10. Expect the sweep unaffected and a single done pulse. A start in the cycle after done launches a second sweep with an identical result.
- X on y: drive y=1'bx for x=9. Expect result[9]===1'bx and match=0. With ERRCNT: err_count=1, first_err=9.
